// File: rtl/sp_arb_ctrl.sv
// sp_arb_ctrl: arbitration and sequencing for the shared 32-byte scratchpad SRAM.
//   Requesters: 1-Wire path (OW_*), host register port (HOST_*) and the internal
//   copy engine that moves scratchpad bytes into main memory (COPY_*).
//   Ports:
//     CLK_MEM, IOX_RSTZ              clock / async active-low reset
//     OW_* / HOST_*                  req/we/addr/wrdata in, gnt/rddata/rvalid out
//     COPY_START/TA/ES               copy command; COPY_BUSY/DONE/ERR, AA status
//     SP_*                           scratchpad SRAM strobes, address, data
//     MEM_WEZ/ADDR/WRDATA, MEM_ACK   main memory write port
module sp_arb_ctrl #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int MAW        = 14,
  parameter int STARVE_LIM = 8
) (
  input  logic           CLK_MEM,
  input  logic           IOX_RSTZ,
  input  logic           OW_REQ,
  input  logic           OW_WE,
  input  logic [AW-1:0]  OW_ADDR,
  input  logic [DW-1:0]  OW_WRDATA,
  output logic           OW_GNT,
  output logic [DW-1:0]  OW_RDDATA,
  output logic           OW_RVALID,
  input  logic           HOST_REQ,
  input  logic           HOST_WE,
  input  logic [AW-1:0]  HOST_ADDR,
  input  logic [DW-1:0]  HOST_WRDATA,
  output logic           HOST_GNT,
  output logic [DW-1:0]  HOST_RDDATA,
  output logic           HOST_RVALID,
  input  logic           COPY_START,
  input  logic [MAW-1:0] COPY_TA,
  input  logic [AW-1:0]  COPY_ES,
  output logic           COPY_BUSY,
  output logic           COPY_DONE,
  output logic           COPY_ERR,
  output logic           AA,
  output logic           SP_MEZ,
  output logic           SP_WEZ,
  output logic           SP_OEZ,
  output logic [AW-1:0]  SP_ADDR,
  output logic [DW-1:0]  SP_WRDATA,
  input  logic [DW-1:0]  SP_RDDATA,
  output logic           MEM_WEZ,
  output logic [MAW-1:0] MEM_ADDR,
  output logic [DW-1:0]  MEM_WRDATA,
  input  logic           MEM_ACK
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_CAP   = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [2:0]     state;
  logic [CW-1:0]  starve;
  logic [AW-1:0]  off, es;
  logic [MAW-1:0] ta;
  logic [AW-1:0]  sp_addr_q;
  logic [DW-1:0]  sp_wrdata_q;
  logic           copy_req, host_force, ow_win, copy_win, host_win;

  // Grants are qualified with reset so no access leaks out while IOX_RSTZ is low.
  assign copy_req   = (state == S_RD);
  assign host_force = HOST_REQ && (starve == CW'(STARVE_LIM));
  assign ow_win     = IOX_RSTZ && OW_REQ && !host_force;
  assign copy_win   = IOX_RSTZ && copy_req && !OW_REQ && !host_force;
  assign host_win   = IOX_RSTZ && HOST_REQ && (host_force || (!OW_REQ && !copy_req));

  assign OW_GNT      = ow_win;
  assign HOST_GNT    = host_win;
  assign OW_RDDATA   = SP_RDDATA;
  assign HOST_RDDATA = SP_RDDATA;

  // Winner steers the SRAM; with no winner address/data hold their last value.
  always_comb begin
    SP_MEZ    = 1'b1;
    SP_WEZ    = 1'b1;
    SP_OEZ    = 1'b1;
    SP_ADDR   = sp_addr_q;
    SP_WRDATA = sp_wrdata_q;
    if (ow_win) begin
      SP_MEZ    = 1'b0;
      SP_WEZ    = ~OW_WE;
      SP_OEZ    = OW_WE;
      SP_ADDR   = OW_ADDR;
      SP_WRDATA = OW_WRDATA;
    end else if (copy_win) begin
      SP_MEZ  = 1'b0;
      SP_OEZ  = 1'b0;
      SP_ADDR = off;
    end else if (host_win) begin
      SP_MEZ    = 1'b0;
      SP_WEZ    = ~HOST_WE;
      SP_OEZ    = HOST_WE;
      SP_ADDR   = HOST_ADDR;
      SP_WRDATA = HOST_WRDATA;
    end
  end

  always_ff @(posedge CLK_MEM or negedge IOX_RSTZ) begin
    if (!IOX_RSTZ) begin
      sp_addr_q   <= '0;
      sp_wrdata_q <= '0;
      OW_RVALID   <= 1'b0;
      HOST_RVALID <= 1'b0;
      starve      <= '0;
    end else begin
      sp_addr_q   <= SP_ADDR;
      sp_wrdata_q <= SP_WRDATA;
      OW_RVALID   <= ow_win && !OW_WE;
      HOST_RVALID <= host_win && !HOST_WE;
      if (!HOST_REQ || host_win)
        starve <= '0;
      else if (starve != CW'(STARVE_LIM))
        starve <= starve + CW'(1);
    end
  end

  // Copy engine
  assign COPY_BUSY = (state != S_IDLE);
  assign COPY_DONE = (state == S_DONE);
  assign MEM_WEZ   = (state != S_WR);

  always_ff @(posedge CLK_MEM or negedge IOX_RSTZ) begin
    if (!IOX_RSTZ) begin
      state      <= S_IDLE;
      off        <= '0;
      es         <= '0;
      ta         <= '0;
      COPY_ERR   <= 1'b0;
      AA         <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WRDATA <= '0;
    end else begin
      case (state)
        S_IDLE: if (COPY_START) begin
          ta       <= COPY_TA;
          off      <= COPY_TA[AW-1:0];
          es       <= COPY_ES;
          AA       <= 1'b0;
          COPY_ERR <= 1'b0;
          state    <= S_CHECK;
        end
        S_CHECK: if (off > es) begin
          COPY_ERR <= 1'b1;
          state    <= S_DONE;
        end else begin
          AA       <= 1'b1;
          MEM_ADDR <= ta;
          state    <= S_RD;
        end
        S_RD:  if (copy_win) state <= S_CAP;
        // SRAM data for the read granted last cycle is valid now.
        S_CAP: begin
          MEM_WRDATA <= SP_RDDATA;
          state      <= S_WR;
        end
        S_WR: if (MEM_ACK) begin
          if (off == es) begin
            state <= S_DONE;
          end else begin
            off      <= off + AW'(1);
            MEM_ADDR <= MEM_ADDR + MAW'(1);
            state    <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_arb_ctrl.sv
// Bench for sp_arb_ctrl: directed arbitration/copy scenarios plus a randomized
// arbitration phase checked against a cycle-level behavioural model.
module tb_sp_arb_ctrl;
  localparam int AW = 5, DW = 8, MAW = 14, LIM = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ow_req = 0, ow_we = 0; logic [AW-1:0] ow_addr = 0; logic [DW-1:0] ow_wd = 0;
  logic h_req = 0, h_we = 0;   logic [AW-1:0] h_addr = 0;  logic [DW-1:0] h_wd = 0;
  logic ow_gnt, ow_rv, h_gnt, h_rv; logic [DW-1:0] ow_rd, h_rd;
  logic cp_start = 0; logic [MAW-1:0] cp_ta = 0; logic [AW-1:0] cp_es = 0;
  logic cp_busy, cp_done, cp_err, aa;
  logic sp_mez, sp_wez, sp_oez; logic [AW-1:0] sp_addr; logic [DW-1:0] sp_wd, sp_rd;
  logic mem_wez, mem_ack; logic [MAW-1:0] mem_addr; logic [DW-1:0] mem_wd;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sp_arb_ctrl #(.AW(AW), .DW(DW), .MAW(MAW), .STARVE_LIM(LIM)) dut (
    .CLK_MEM(clk), .IOX_RSTZ(rst_n),
    .OW_REQ(ow_req), .OW_WE(ow_we), .OW_ADDR(ow_addr), .OW_WRDATA(ow_wd),
    .OW_GNT(ow_gnt), .OW_RDDATA(ow_rd), .OW_RVALID(ow_rv),
    .HOST_REQ(h_req), .HOST_WE(h_we), .HOST_ADDR(h_addr), .HOST_WRDATA(h_wd),
    .HOST_GNT(h_gnt), .HOST_RDDATA(h_rd), .HOST_RVALID(h_rv),
    .COPY_START(cp_start), .COPY_TA(cp_ta), .COPY_ES(cp_es),
    .COPY_BUSY(cp_busy), .COPY_DONE(cp_done), .COPY_ERR(cp_err), .AA(aa),
    .SP_MEZ(sp_mez), .SP_WEZ(sp_wez), .SP_OEZ(sp_oez), .SP_ADDR(sp_addr),
    .SP_WRDATA(sp_wd), .SP_RDDATA(sp_rd),
    .MEM_WEZ(mem_wez), .MEM_ADDR(mem_addr), .MEM_WRDATA(mem_wd), .MEM_ACK(mem_ack)
  );

  // Scratchpad SRAM: synchronous, 1-cycle read latency
  logic [DW-1:0] sram [32];
  always @(posedge clk)
    if (!sp_mez) begin
      if (!sp_wez)      sram[sp_addr] <= sp_wd;
      else if (!sp_oez) sp_rd <= sram[sp_addr];
    end

  // Main memory: ACK two cycles after MEM_WEZ falls, log completed writes
  int wcnt, wez_low = 0, done_cnt = 0;
  logic [MAW+DW-1:0] wlog [$];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= 0; mem_ack <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      if (!mem_wez && !mem_ack) begin
        if (wcnt == 1) begin mem_ack <= 1'b1; wcnt <= 0; end
        else wcnt <= wcnt + 1;
      end else wcnt <= 0;
    end
  always @(posedge clk) begin
    if (rst_n && !mem_wez && mem_ack) wlog.push_back({mem_addr, mem_wd});
    if (!mem_wez) wez_low <= wez_low + 1;
    if (cp_done)  done_cnt <= done_cnt + 1;
  end

  logic [DW-1:0] ref_sp [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic ow_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ow_req = 1; ow_we = 1; ow_addr = a; ow_wd = d;
    @(negedge clk); chk("preload_gnt", ow_gnt, 1);
    tick(); ow_req = 0; ow_we = 0;
    ref_sp[a] = d;
  endtask

  task automatic preload();
    for (int a = 0; a < 32; a++) ow_write(AW'(a), DW'(a));
    tick();
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_ow_gnt"}, ow_gnt, 0);   chk({tag, "_h_gnt"}, h_gnt, 0);
    chk({tag, "_ow_rv"}, ow_rv, 0);     chk({tag, "_h_rv"}, h_rv, 0);
    chk({tag, "_strobes"}, {sp_mez, sp_wez, sp_oez}, 3'b111);
    chk({tag, "_sp_addr"}, sp_addr, 0); chk({tag, "_sp_wd"}, sp_wd, 0);
    chk({tag, "_mem_wez"}, mem_wez, 1); chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wd"}, mem_wd, 0);
    chk({tag, "_status"}, {cp_busy, cp_done, cp_err, aa}, 4'b0000);
  endtask

  // Start a copy and wait (bounded) for its DONE pulse; optionally toggle OW reads.
  task automatic run_copy(input string tag, input logic [MAW-1:0] ta,
                          input logic [AW-1:0] es, input bit ow_toggle, input bit restart);
    int d0, n;
    d0 = done_cnt; n = 0;
    wlog.delete();
    cp_ta = ta; cp_es = es; cp_start = 1; tick(); cp_start = 0;
    if (restart) begin
      cp_ta = 14'h0000; cp_es = 5'd1; cp_start = 1; tick(); cp_start = 0;
    end
    while (done_cnt == d0 && n < 300) begin
      if (ow_toggle) begin
        ow_req = ~ow_req; ow_we = 0; ow_addr = 5'h1f;
        @(negedge clk); chk({tag, "_ow_prio"}, ow_gnt, ow_req);
      end
      tick(); n++;
    end
    ow_req = 0;
    chk({tag, "_done"}, done_cnt, d0 + 1);
    tick();
    chk({tag, "_single_done"}, done_cnt, d0 + 1);
    chk({tag, "_busy_low"}, cp_busy, 0);
  endtask

  logic          eo, eh, fo, exp_orv, exp_hrv;
  logic [DW-1:0] exp_ord, exp_hrd;
  int            mcnt, wl0, d1, n;
  logic [MAW-1:0] eaddr;

  initial begin
    // reset state
    ow_req = 1; h_req = 1;
    #3 reset_outputs("reset0");
    ow_req = 0; h_req = 0;
    tick(); rst_n = 1; tick();

    preload();

    // OW and HOST write the same address in the same cycle
    ow_req = 1; ow_we = 1; ow_addr = 5; ow_wd = 8'h11;
    h_req = 1;  h_we = 1;  h_addr = 5;  h_wd = 8'h22;
    @(negedge clk); chk("conf_ow_gnt", ow_gnt, 1); chk("conf_h_gnt", h_gnt, 0);
    tick(); ow_req = 0;
    @(negedge clk); chk("conf_h_gnt2", h_gnt, 1);
    tick(); h_req = 0; ref_sp[5] = 8'h22;
    ow_req = 1; ow_we = 0; ow_addr = 5;
    @(negedge clk); chk("conf_rd_gnt", ow_gnt, 1);
    tick(); ow_req = 0;
    @(negedge clk); chk("conf_rv", ow_rv, 1); chk("conf_rdata", ow_rd, 8'h22);
    chk("conf_h_rv", h_rv, 0);
    tick(); tick();

    // starvation: OW held, HOST held; host wins in cycle 9, then again in cycle 18
    ow_req = 1; ow_we = 0; ow_addr = 0;
    h_req = 1; h_we = 1; h_addr = 9; h_wd = 8'h5a;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk($sformatf("starve_h_c%0d", c), h_gnt, (c == 9 || c == 18));
      chk($sformatf("starve_ow_c%0d", c), ow_gnt, !(c == 9 || c == 18));
      tick();
      if (c == 9) begin ref_sp[9] = 8'h5a; h_we = 0; end
    end
    ow_req = 0; h_req = 0;
    @(negedge clk); chk("starve_h_rv", h_rv, 1); chk("starve_h_rd", h_rd, 8'h5a);
    tick(); tick();

    // randomized arbitration against the model
    mcnt = 0; exp_orv = 0; exp_hrv = 0; exp_ord = 0; exp_hrd = 0; eo = 1; eh = 1;
    for (int c = 0; c < 400; c++) begin
      if (eo || !ow_req) begin
        ow_req = ($urandom % 4) != 0; ow_we = 1'($urandom);
        ow_addr = AW'($urandom); ow_wd = DW'($urandom);
      end
      if (eh || !h_req) begin
        h_req = ($urandom % 3) != 0; h_we = 1'($urandom);
        h_addr = AW'($urandom); h_wd = DW'($urandom);
      end
      @(negedge clk);
      chk("rnd_ow_rv", ow_rv, exp_orv);
      if (exp_orv) chk("rnd_ow_rd", ow_rd, exp_ord);
      chk("rnd_h_rv", h_rv, exp_hrv);
      if (exp_hrv) chk("rnd_h_rd", h_rd, exp_hrd);
      fo = h_req && (mcnt == LIM);
      eo = ow_req && !fo;
      eh = h_req && !eo;
      chk("rnd_ow_gnt", ow_gnt, eo);
      chk("rnd_h_gnt", h_gnt, eh);
      exp_orv = eo && !ow_we; exp_ord = ref_sp[ow_addr];
      exp_hrv = eh && !h_we;  exp_hrd = ref_sp[h_addr];
      if (eo && ow_we) ref_sp[ow_addr] = ow_wd;
      if (eh && h_we)  ref_sp[h_addr]  = h_wd;
      mcnt = (!h_req || eh) ? 0 : ((mcnt < LIM) ? mcnt + 1 : LIM);
      tick();
    end
    ow_req = 0; h_req = 0; tick(); tick();

    // copy: 4 bytes from offset 4 to 0x0104
    preload();
    run_copy("copyA", 14'h0104, 5'd7, 0, 0);
    chk("copyA_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk($sformatf("copyA_w%0d", i), wlog[i], {14'h0104 + 14'(i), 8'(4 + i)});
    chk("copyA_aa", aa, 1); chk("copyA_err", cp_err, 0);

    // copy: start offset beyond end -> error, START while busy ignored
    wl0 = wez_low;
    run_copy("copyB", 14'h0009, 5'd3, 0, 1);
    chk("copyB_err", cp_err, 1); chk("copyB_aa", aa, 0);
    repeat (10) tick();
    chk("copyB_no_wez", wez_low, wl0); chk("copyB_no_writes", wlog.size(), 0);
    chk("copyB_idle", cp_busy, 0);

    // copy with OW requests every other cycle
    run_copy("copyC", 14'h0200, 5'd5, 1, 0);
    chk("copyC_count", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      eaddr = 14'h0200 + 14'(i);
      chk($sformatf("copyC_w%0d", i), wlog[i], {eaddr, 8'(i)});
    end

    // reset during WR aborts the copy with no DONE pulse
    d1 = done_cnt; n = 0;
    cp_ta = 14'h0310; cp_es = 5'd31; cp_start = 1; tick(); cp_start = 0;
    while (mem_wez && n < 50) begin tick(); n++; end
    chk("copyD_in_wr", mem_wez, 0);
    ow_req = 1; ow_we = 1; ow_addr = 3; ow_wd = 8'h77;
    #2 rst_n = 0;
    #1 reset_outputs("midreset");
    ow_req = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (10) tick();
    chk("copyD_no_done", done_cnt, d1);
    chk("copyD_idle", cp_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
